// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency-sweep learning controller:
// filter-type codes reported on filter_type and the controller state encoding.
package sweep_pkg;

    localparam logic [2:0] FT_NONE = 3'd0;
    localparam logic [2:0] FT_LPF  = 3'd1;
    localparam logic [2:0] FT_HPF  = 3'd2;
    localparam logic [2:0] FT_BPF  = 3'd3;
    localparam logic [2:0] FT_BSF  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEAS,
        S_STORE,
        S_CLASSIFY,
        S_DONE
    } state_t;

endpackage

// File: rtl/sweep_classifier.sv
// Combinational filter classification from the sweep end points and the
// max/min trackers. A point is "high" when twice its magnitude reaches the
// sweep maximum; the comparison is one bit wider so doubling cannot overflow.
module sweep_classifier
    import sweep_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int ADDR_W   = 6,
    parameter int MAG_W    = 16
) (
    input  logic [MAG_W-1:0]  m0,
    input  logic [MAG_W-1:0]  ml,
    input  logic [MAG_W-1:0]  max_mag,
    input  logic [MAG_W-1:0]  min_mag,
    input  logic [ADDR_W-1:0] max_idx,
    input  logic [ADDR_W-1:0] min_idx,
    output logic [2:0]        filter_type
);

    localparam logic [ADDR_W-1:0] LAST_PT = ADDR_W'(N_POINTS - 1);

    logic [MAG_W:0] max_w;
    logic           hi0;
    logic           hil;
    logic           min_deep;
    logic           max_inner;
    logic           min_inner;

    assign max_w     = {1'b0, max_mag};
    assign hi0       = {m0, 1'b0} >= max_w;
    assign hil       = {ml, 1'b0} >= max_w;
    assign min_deep  = {min_mag, 1'b0} < max_w;
    assign max_inner = (max_idx != '0) && (max_idx != LAST_PT);
    assign min_inner = (min_idx != '0) && (min_idx != LAST_PT);

    // Decide the response shape; a flat-zero or single-point sweep stays unknown.
    always_comb begin
        filter_type = FT_NONE;
        if ((N_POINTS > 1) && (max_mag != '0)) begin
            if (hi0 && !hil)
                filter_type = FT_LPF;
            else if (!hi0 && hil)
                filter_type = FT_HPF;
            else if (!hi0 && !hil && max_inner)
                filter_type = FT_BPF;
            else if (hi0 && hil && min_deep && min_inner)
                filter_type = FT_BSF;
        end
    end

endmodule

// File: rtl/sweep_learn_ctrl.sv
// Frequency-sweep learning controller: steps the DDS over N_POINTS tones,
// waits for the analog path to settle, averages 2^AVG_LOG2 magnitude readings
// per tone into the response RAM, then classifies the filter and reports the peak.
module sweep_learn_ctrl
    import sweep_pkg::*;
#(
    parameter int N_POINTS    = 64,
    parameter int ADDR_W      = 6,
    parameter int FREQ_W      = 16,
    parameter int MAG_W       = 16,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 50000,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] freq_base,
    input  logic [FREQ_W-1:0] freq_step,
    output logic [FREQ_W-1:0] dds_freq,
    output logic              dds_load,
    output logic              meas_req,
    input  logic              mag_valid,
    input  logic [MAG_W-1:0]  mag_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [MAG_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [2:0]        filter_type,
    output logic [MAG_W-1:0]  peak_mag,
    output logic [ADDR_W-1:0] peak_idx
);

    localparam int                ACC_W       = MAG_W + AVG_LOG2;
    localparam int                NREADS      = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST_RD     = (AVG_LOG2 + 1)'(NREADS - 1);
    localparam logic [ADDR_W-1:0] LAST_PT     = ADDR_W'(N_POINTS - 1);
    localparam logic [31:0]       SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]       TMO_LAST    = 32'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       cnt;
    logic [AVG_LOG2:0] nread;
    logic              timed_out;

    logic [FREQ_W-1:0] step_r;
    logic [FREQ_W-1:0] freq_cur;
    logic [ACC_W-1:0]  acc;
    logic [MAG_W-1:0]  m0;
    logic [MAG_W-1:0]  ml;
    logic [MAG_W-1:0]  max_mag;
    logic [MAG_W-1:0]  min_mag;
    logic [ADDR_W-1:0] max_idx;
    logic [ADDR_W-1:0] min_idx;
    logic [MAG_W-1:0]  store_val;
    logic [2:0]        ft_calc;

    // Averaged magnitude: plain truncation of the accumulated sum.
    function automatic logic [MAG_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        avg_trunc = MAG_W'(sum >> AVG_LOG2);
    endfunction

    // A timed-out point is recorded as zero regardless of partial readings.
    assign store_val = timed_out ? '0 : avg_trunc(acc);

    sweep_classifier #(
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W),
        .MAG_W    (MAG_W)
    ) u_classifier (
        .m0          (m0),
        .ml          (ml),
        .max_mag     (max_mag),
        .min_mag     (min_mag),
        .max_idx     (max_idx),
        .min_idx     (min_idx),
        .filter_type (ft_calc)
    );

    // Sweep sequencing FSM with registered control outputs; abort overrides everything.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            nread       <= '0;
            timed_out   <= 1'b0;
            dds_freq    <= '0;
            dds_load    <= 1'b0;
            meas_req    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            filter_type <= FT_NONE;
            peak_mag    <= '0;
            peak_idx    <= '0;
        end else begin
            dds_load <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                meas_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state       <= S_LOAD;
                            busy        <= 1'b1;
                            idx         <= '0;
                            err_timeout <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        dds_freq <= freq_cur;
                        dds_load <= 1'b1;
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt       <= '0;
                            nread     <= '0;
                            timed_out <= 1'b0;
                            meas_req  <= 1'b1;
                            state     <= S_MEAS;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_MEAS: begin
                        if (mag_valid) begin
                            cnt <= '0;
                            if (nread == LAST_RD) begin
                                meas_req <= 1'b0;
                                state    <= S_STORE;
                            end else begin
                                nread <= nread + 1'b1;
                            end
                        end else if (cnt == TMO_LAST) begin
                            err_timeout <= 1'b1;
                            timed_out   <= 1'b1;
                            meas_req    <= 1'b0;
                            state       <= S_STORE;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_STORE: begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= store_val;
                        if (idx == LAST_PT) begin
                            state <= S_CLASSIFY;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_CLASSIFY: begin
                        filter_type <= ft_calc;
                        peak_mag    <= max_mag;
                        peak_idx    <= max_idx;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Sweep datapath: frequency adder, reading accumulator, end points and peak trackers.
    always_ff @(posedge clk_50m) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    step_r   <= freq_step;
                    freq_cur <= freq_base;
                    max_mag  <= '0;
                    max_idx  <= '0;
                    min_mag  <= '1;
                    min_idx  <= '0;
                end
            end
            S_SETTLE: begin
                acc <= '0;
            end
            S_MEAS: begin
                if (mag_valid)
                    acc <= acc + ACC_W'(mag_data);
            end
            S_STORE: begin
                freq_cur <= freq_cur + step_r;
                if (idx == '0)
                    m0 <= store_val;
                if (idx == LAST_PT)
                    ml <= store_val;
                if (store_val > max_mag) begin
                    max_mag <= store_val;
                    max_idx <= idx;
                end
                if (store_val < min_mag) begin
                    min_mag <= store_val;
                    min_idx <= idx;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sweep_learn_ctrl.sv
// Self-checking bench for sweep_learn_ctrl: table-driven sweeps with a
// randomised magnitude responder, checked against an array-level model.
module tb_sweep_learn_ctrl;

    localparam int NP = 8;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] freq_base;
    logic [15:0] freq_step;
    logic [15:0] dds_freq;
    logic        dds_load;
    logic        meas_req;
    logic        mag_valid;
    logic [15:0] mag_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [2:0]  filter_type;
    logic [15:0] peak_mag;
    logic [2:0]  peak_idx;

    sweep_learn_ctrl #(
        .N_POINTS    (NP),
        .ADDR_W      (3),
        .FREQ_W      (16),
        .MAG_W       (16),
        .AVG_LOG2    (2),
        .SETTLE_CYC  (10),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .freq_base   (freq_base),
        .freq_step   (freq_step),
        .dds_freq    (dds_freq),
        .dds_load    (dds_load),
        .meas_req    (meas_req),
        .mag_valid   (mag_valid),
        .mag_data    (mag_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .filter_type (filter_type),
        .peak_mag    (peak_mag),
        .peak_idx    (peak_idx)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        int          kind;
        logic [15:0] base;
        logic [15:0] step;
        int          to_pt;
        int          exp_ft;
        int          exp_pidx;
        int          exp_pmag;
        int          exp_err;
        int          poke;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   rd [NP][4];
    int   to_pt_g = -1;
    int   exp_avg [NP];
    int   m_ft, m_pidx, m_pmag;
    int   wr_cnt, done_cnt, load_cnt;
    int   ram [NP];
    logic [15:0] freq_q [$];
    int   resp_pt, resp_cnt, resp_gap;
    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: records RAM writes, DDS loads and done pulses of the current sweep.
    initial begin
        wr_cnt = 0; done_cnt = 0; load_cnt = 0;
        for (int i = 0; i < NP; i++) ram[i] = -1;
        forever begin
            @(negedge clk_50m);
            if (rst_n && start && !abort && !busy) begin
                wr_cnt = 0; done_cnt = 0; load_cnt = 0;
                freq_q.delete();
                for (int i = 0; i < NP; i++) ram[i] = -1;
            end
            if (wr_en) begin
                wr_cnt++;
                ram[wr_addr] = int'(wr_data);
            end
            if (dds_load) begin
                load_cnt++;
                freq_q.push_back(dds_freq);
            end
            if (done) done_cnt++;
        end
    end

    // Responder: supplies 4 readings per point with random gaps, plus stray strobes outside MEAS.
    initial begin
        resp_pt = -1; resp_cnt = 0; resp_gap = 0;
        mag_valid = 1'b0; mag_data = '0;
        forever begin
            @(negedge clk_50m);
            mag_valid = 1'b0;
            mag_data  = 16'($urandom);
            if (!busy) resp_pt = -1;
            if (dds_load) begin
                resp_pt++;
                resp_cnt = 0;
                resp_gap = $urandom_range(0, 2);
            end
            if (meas_req) begin
                if (resp_pt >= 0 && resp_pt < NP && resp_pt != to_pt_g && resp_cnt < 4) begin
                    if (resp_gap > 0) begin
                        resp_gap--;
                    end else begin
                        mag_valid = 1'b1;
                        mag_data  = 16'(rd[resp_pt][resp_cnt]);
                        resp_cnt++;
                        resp_gap = $urandom_range(0, 2);
                    end
                end
            end else if (busy && $urandom_range(0, 5) == 0) begin
                mag_valid = 1'b1;
                mag_data  = 16'hFFFF;
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill(input int kind);
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 4; k++)
                case (kind)
                    0: rd[p][k] = 1000 - 100 * p;
                    1: rd[p][k] = (p == 3) ? 10 + 2 * k : 0;
                    2: rd[p][k] = (p == 2) ? 100 : 800;
                    3: rd[p][k] = 100 * (p + 1);
                    default: rd[p][k] = $urandom_range(0, 65535);
                endcase
    endtask

    // Reference: average each point, find first max/min, apply the shape rules.
    task automatic model(input int to_pt);
        int s, mn, midx;
        bit hi0, hil;
        for (int p = 0; p < NP; p++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += rd[p][k];
            exp_avg[p] = (p == to_pt) ? 0 : s / 4;
        end
        m_pmag = exp_avg[0]; m_pidx = 0; mn = exp_avg[0]; midx = 0;
        for (int p = 1; p < NP; p++) begin
            if (exp_avg[p] > m_pmag) begin m_pmag = exp_avg[p]; m_pidx = p; end
            if (exp_avg[p] < mn) begin mn = exp_avg[p]; midx = p; end
        end
        hi0 = (2 * exp_avg[0] >= m_pmag);
        hil = (2 * exp_avg[NP-1] >= m_pmag);
        m_ft = 0;
        if (m_pmag != 0) begin
            if (hi0 && !hil) m_ft = 1;
            else if (!hi0 && hil) m_ft = 2;
            else if (!hi0 && !hil && m_pidx > 0 && m_pidx < NP - 1) m_ft = 3;
            else if (hi0 && hil && 2 * mn < m_pmag && midx > 0 && midx < NP - 1) m_ft = 4;
        end
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] s);
        freq_base = b; freq_step = s; start = 1'b1;
        @(posedge clk_50m); #2;
        start = 1'b0; freq_base = 16'h5A5A; freq_step = 16'hA5A5;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int guard;
        logic [15:0] f;
        fill(v.kind);
        to_pt_g = v.to_pt;
        model(v.to_pt);
        pulse_start(v.base, v.step);
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            start = (v.poke != 0 && guard == 60) ? 1'b1 : 1'b0;
            @(posedge clk_50m); #2;
            guard++;
        end
        start = 1'b0;
        chk($sformatf("v%0d done_in_time", id), int'(guard < 4000), 1);
        repeat (5) begin @(posedge clk_50m); #2; end
        chk($sformatf("v%0d done_pulses", id), done_cnt, 1);
        chk($sformatf("v%0d wr_count", id), wr_cnt, NP);
        chk($sformatf("v%0d busy_after", id), int'(busy), 0);
        chk($sformatf("v%0d err_timeout", id), int'(err_timeout), v.exp_err);
        chk($sformatf("v%0d load_count", id), freq_q.size(), NP);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("v%0d ram[%0d]", id, p), ram[p], exp_avg[p]);
            f = v.base + 16'(p) * v.step;
            if (p < freq_q.size())
                chk($sformatf("v%0d dds_freq[%0d]", id, p), int'(freq_q[p]), int'(f));
        end
        chk($sformatf("v%0d filter_type", id), int'(filter_type), m_ft);
        chk($sformatf("v%0d peak_idx", id), int'(peak_idx), m_pidx);
        chk($sformatf("v%0d peak_mag", id), int'(peak_mag), m_pmag);
        if (v.exp_ft >= 0) begin
            chk($sformatf("v%0d filter_type_tbl", id), int'(filter_type), v.exp_ft);
            chk($sformatf("v%0d peak_idx_tbl", id), int'(peak_idx), v.exp_pidx);
            chk($sformatf("v%0d peak_mag_tbl", id), int'(peak_mag), v.exp_pmag);
        end
    endtask

    initial begin
        int guard;
        int prev_ft;
        vecs[0] = '{0, 16'h1000, 16'h0100, -1, 1, 0, 1000, 0, 0};
        vecs[1] = '{1, 16'hFFF0, 16'h0008, -1, 3, 3, 13, 0, 0};
        vecs[2] = '{0, 16'h0400, 16'h0040, 5, 1, 0, 1000, 1, 0};
        vecs[3] = '{2, 16'h2000, 16'h0010, -1, 4, 0, 800, 0, 1};
        vecs[4] = '{3, 16'h0000, 16'hFFFF, -1, 2, 7, 800, 0, 0};
        for (int i = 5; i < 8; i++)
            vecs[i] = '{4, 16'($urandom), 16'($urandom), -1, -1, 0, 0, 0, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        freq_base = '0; freq_step = '0;
        repeat (3) @(posedge clk_50m);
        #2;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst dds_load", int'(dds_load), 0);
        chk("rst dds_freq", int'(dds_freq), 0);
        chk("rst meas_req", int'(meas_req), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst err_timeout", int'(err_timeout), 0);
        chk("rst filter_type", int'(filter_type), 0);
        chk("rst peak_mag", int'(peak_mag), 0);
        chk("rst peak_idx", int'(peak_idx), 0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk_50m); #2; end

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Abort during SETTLE of point 4.
        prev_ft = m_ft;
        fill(0);
        to_pt_g = -1;
        pulse_start(16'h0100, 16'h0010);
        guard = 0;
        while (load_cnt < 5 && guard < 2000) begin
            @(posedge clk_50m); #2;
            guard++;
        end
        chk("abort reached_point4", int'(guard < 2000), 1);
        abort = 1'b1;
        @(posedge clk_50m); #2;
        abort = 1'b0;
        chk("abort busy_next", int'(busy), 0);
        chk("abort meas_req", int'(meas_req), 0);
        repeat (300) begin @(posedge clk_50m); #2; end
        chk("abort no_done", done_cnt, 0);
        chk("abort wr_count", wr_cnt, 4);
        chk("abort loads", load_cnt, 5);
        chk("abort filter_kept", int'(filter_type), prev_ft);

        // start and abort together while idle: stay idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk_50m); #2;
        start = 1'b0; abort = 1'b0;
        repeat (3) begin @(posedge clk_50m); #2; end
        chk("start_abort busy", int'(busy), 0);
        chk("start_abort loads", load_cnt, 5);

        run_vec(vecs[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
